cam_ctrl: RTL and testbench

CAM_CTRL -- requirements
Module: cam_ctrl

---
 rtl/cam_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// cam_ctrl: front end for a CAM macro.
//  - Arbitrates NUM_REQ update requesters (round robin) onto the CAM write
//    port, one operation at a time, and keeps an occupancy bitmap of valid
//    entries so that adds to a taken slot become delete+write (replace) and
//    deletes of empty slots complete with an error without touching the CAM.
//  - Sequences single-outstanding lookups on the CAM search port, with a
//    fixed two-cycle accept-to-response latency.
//
// Handshake rule (upd_* and lk_*): a transfer happens on the rising clock edge
// where valid and ready are both high. Ready is a combinational function of
// the controller state and the valid inputs; a requester must raise valid
// without waiting for ready and hold its fields stable while valid is high.
module cam_ctrl #(
  parameter int  DATA_WIDTH = 64,
  parameter int  ADDR_WIDTH = 5,
  parameter int  NUM_REQ    = 2,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int NUM_ENT    = 2 ** ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // update requesters
  input  logic [NUM_REQ-1:0]            upd_valid,
  output logic [NUM_REQ-1:0]            upd_ready,
  input  logic [NUM_REQ-1:0]            upd_op,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] upd_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] upd_data,
  // completion
  output logic                          done_valid,
  output logic [ID_W-1:0]               done_id,
  output logic                          done_err,
  // lookup
  input  logic                          lk_valid,
  output logic                          lk_ready,
  input  logic [DATA_WIDTH-1:0]         lk_data,
  output logic                          lk_resp_valid,
  output logic                          lk_hit,
  output logic [ADDR_WIDTH-1:0]         lk_addr,
  // CAM write port
  output logic [ADDR_WIDTH-1:0]         cam_write_addr,
  output logic [DATA_WIDTH-1:0]         cam_write_data,
  output logic                          cam_write_enable,
  output logic                          cam_write_delete,
  input  logic                          cam_write_busy,
  // CAM search port
  output logic [DATA_WIDTH-1:0]         cam_compare_data,
  input  logic [ADDR_WIDTH-1:0]         cam_match_addr,
  input  logic                          cam_match,
  // status
  output logic [NUM_ENT-1:0]            occupied,
  output logic [3:0]                    dbg_state
);

  typedef enum logic [3:0] {
    S_INIT        = 4'd0,
    S_IDLE        = 4'd1,
    S_DEL_ISSUE   = 4'd2,
    S_DEL_WAIT_HI = 4'd3,
    S_DEL_WAIT_LO = 4'd4,
    S_WR_ISSUE    = 4'd5,
    S_WR_WAIT_HI  = 4'd6,
    S_WR_WAIT_LO  = 4'd7,
    S_DONE        = 4'd8
  } state_e;

  // update FSM and latched request
  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;       // highest-priority requester next round
  logic [ID_W-1:0]        id_q, id_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   replace_q, replace_d; // add onto an occupied entry
  logic                   err_q, err_d;         // delete of an empty entry
  logic [NUM_ENT-1:0]     occ_q, occ_d;

  // lookup pipeline
  logic [DATA_WIDTH-1:0]  cmp_q;
  logic                   lk_pend_q;  // compare data presented, match sampled next edge
  logic                   lk_resp_q;
  logic                   lk_hit_q;
  logic [ADDR_WIDTH-1:0]  lk_addr_q;

  // arbiter results
  logic                   found_hi, found_lo;
  logic [ID_W-1:0]        idx_hi, idx_lo;
  logic [ID_W-1:0]        grant_idx;
  logic                   any_req;
  logic                   grant;
  logic                   sel_op;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   lk_fire;

  // Round-robin pick: first valid index at or above the pointer, otherwise the
  // first valid index overall (wrap-around); then mux out that requester's fields.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && upd_valid[i] && (ID_W'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = ID_W'(i);
      end
      if (!found_lo && upd_valid[i]) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(i);
      end
    end
    any_req   = found_lo;
    grant_idx = found_hi ? idx_hi : idx_lo;
    sel_op    = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_op   = upd_op[i];
        sel_addr = upd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = upd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Updates win over lookups; a lookup waits while its predecessor's match
  // has not yet been captured.
  assign grant     = (state_q == S_IDLE) && any_req;
  assign upd_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign lk_ready  = (state_q == S_IDLE) && !any_req && !lk_pend_q;
  assign lk_fire   = lk_valid && lk_ready;

  // Next-state logic for the update FSM, latching the granted request and
  // maintaining the occupancy bitmap as CAM operations complete.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    data_d    = data_q;
    replace_d = replace_q;
    err_d     = err_q;
    occ_d     = occ_q;
    case (state_q)
      S_INIT: begin
        if (!cam_write_busy) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (grant) begin
          ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          id_d      = grant_idx;
          addr_d    = sel_addr;
          data_d    = sel_data;
          replace_d = !sel_op && occ_q[sel_addr];
          err_d     = sel_op && !occ_q[sel_addr];
          if (sel_op) begin
            state_d = occ_q[sel_addr] ? S_DEL_ISSUE : S_DONE;
          end else begin
            state_d = occ_q[sel_addr] ? S_DEL_ISSUE : S_WR_ISSUE;
          end
        end
      end
      S_DEL_ISSUE: state_d = S_DEL_WAIT_HI;
      S_DEL_WAIT_HI: begin
        if (cam_write_busy) state_d = S_DEL_WAIT_LO;
      end
      S_DEL_WAIT_LO: begin
        if (!cam_write_busy) begin
          if (replace_q) begin
            state_d = S_WR_ISSUE;
          end else begin
            occ_d[addr_q] = 1'b0;
            state_d       = S_DONE;
          end
        end
      end
      S_WR_ISSUE: state_d = S_WR_WAIT_HI;
      S_WR_WAIT_HI: begin
        if (cam_write_busy) state_d = S_WR_WAIT_LO;
      end
      S_WR_WAIT_LO: begin
        if (!cam_write_busy) begin
          occ_d[addr_q] = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Update FSM state, round-robin pointer, latched request and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      ptr_q     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      replace_q <= 1'b0;
      err_q     <= 1'b0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      replace_q <= replace_d;
      err_q     <= err_d;
      occ_q     <= occ_d;
    end
  end

  // Lookup pipeline: register the key on accept, capture the CAM match one
  // cycle later, present the response for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q     <= '0;
      lk_pend_q <= 1'b0;
      lk_resp_q <= 1'b0;
      lk_hit_q  <= 1'b0;
      lk_addr_q <= '0;
    end else begin
      if (lk_fire) cmp_q <= lk_data;
      lk_pend_q <= lk_fire;
      lk_resp_q <= lk_pend_q;
      if (lk_pend_q) begin
        lk_hit_q  <= cam_match;
        lk_addr_q <= cam_match_addr;
      end
    end
  end

  // Output decode: write strobes are single-cycle because the issue states
  // always advance after one cycle.
  assign cam_write_enable = (state_q == S_WR_ISSUE);
  assign cam_write_delete = (state_q == S_DEL_ISSUE);
  assign cam_write_addr   = addr_q;
  assign cam_write_data   = data_q;
  assign done_valid       = (state_q == S_DONE);
  assign done_err         = (state_q == S_DONE) && err_q;
  assign done_id          = id_q;
  assign cam_compare_data = cmp_q;
  assign lk_resp_valid    = lk_resp_q;
  assign lk_hit           = lk_hit_q;
  assign lk_addr          = lk_addr_q;
  assign occupied         = occ_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: a CAM responder model, a transaction-level model of the
// controller's visible behaviour with a per-cycle compare process, and
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_cam_ctrl;
  localparam int DW   = 64;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int IDW  = 1;
  localparam int NENT = 32;
  localparam int PW   = 1 + AW + DW;     // {is_del, addr, data}
  localparam int DQW  = IDW + 1 + NENT;  // {id, err, occupied}
  localparam int LQW  = 32 + 1 + AW;     // {due cycle, hit, addr}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    upd_valid, upd_ready, upd_op;
  logic [NR*AW-1:0] upd_addr;
  logic [NR*DW-1:0] upd_data;
  logic             done_valid, done_err;
  logic [IDW-1:0]   done_id;
  logic             lk_valid, lk_ready, lk_resp_valid, lk_hit;
  logic [DW-1:0]    lk_data;
  logic [AW-1:0]    lk_addr;
  logic [AW-1:0]    cam_write_addr;
  logic [DW-1:0]    cam_write_data;
  logic             cam_write_enable, cam_write_delete;
  logic             cam_write_busy = 1'b1;
  logic [DW-1:0]    cam_compare_data;
  logic [AW-1:0]    cam_match_addr = '0;
  logic             cam_match = 1'b0;
  logic [NENT-1:0]  occupied;
  logic [3:0]       dbg_state;

  cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
    .upd_addr(upd_addr), .upd_data(upd_data),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_data(lk_data),
    .lk_resp_valid(lk_resp_valid), .lk_hit(lk_hit), .lk_addr(lk_addr),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_enable(cam_write_enable), .cam_write_delete(cam_write_delete),
    .cam_write_busy(cam_write_busy),
    .cam_compare_data(cam_compare_data), .cam_match_addr(cam_match_addr),
    .cam_match(cam_match),
    .occupied(occupied), .dbg_state(dbg_state)
  );

  // ---------------- counters ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- CAM responder (acts 1ns after each rising edge) ----------------
  int init_cyc = 20;
  int init_cnt = 0;
  int op_cnt = 0;
  logic          cam_v [NENT];
  logic [DW-1:0] cam_d [NENT];

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      init_cnt = init_cyc;
      op_cnt = 0;
      cam_write_busy = 1'b1;
      for (int i = 0; i < NENT; i++) begin cam_v[i] = 1'b0; cam_d[i] = '0; end
    end else begin
      if (cam_write_enable) begin
        cam_v[cam_write_addr] = 1'b1;
        cam_d[cam_write_addr] = cam_write_data;
        op_cnt = 3;
      end else if (cam_write_delete) begin
        cam_v[cam_write_addr] = 1'b0;
        op_cnt = 3;
      end else if (op_cnt > 0) begin
        op_cnt--;
      end
      if (init_cnt > 0) init_cnt--;
      cam_write_busy = (init_cnt > 0) || (op_cnt > 0);
    end
    cam_match = 1'b0;
    cam_match_addr = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (cam_v[i] && cam_d[i] == cam_compare_data) begin
        cam_match = 1'b1;
        cam_match_addr = AW'(i);
      end
    end
  end

  // ---------------- model + scoreboard (compares 2ns after each falling edge) ----------------
  logic [PW-1:0]  exp_q[$];
  logic [DQW-1:0] done_q[$];
  logic [LQW-1:0] lk_q[$];
  int             grant_log[$];
  logic [NENT-1:0] m_occ = '0;
  logic [DW-1:0]   m_data [NENT];
  int m_ptr = 0;
  int cyc = 0;
  int n_done = 0, n_wen = 0, n_del = 0, n_resp = 0;
  int wen_cyc = 0, acc_cyc = 0, last_lat = 0;
  logic last_err = 1'b0, last_hit = 1'b0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    int g, eg, c;
    logic op, err, hit;
    logic [AW-1:0] a, ha;
    logic [DW-1:0] d;
    logic [PW-1:0] pe;
    logic [DQW-1:0] de;
    logic [LQW-1:0] le;
    #2;
    cyc++;
    if (!rst_n) begin
      exp_q.delete(); done_q.delete(); lk_q.delete();
      m_occ = '0; m_ptr = 0;
    end else begin
      chk("ready_onehot", {63'd0, $onehot0(upd_ready)}, 64'd1);
      chk("ready_only_when_valid", {62'd0, upd_ready & ~upd_valid}, 64'd0);
      chk("en_del_exclusive", {63'd0, cam_write_enable & cam_write_delete}, 64'd0);
      chk("lookup_yields_to_update", {63'd0, lk_ready & (|upd_valid)}, 64'd0);
      // grant: round robin from the index after the previous grant
      if (|(upd_valid & upd_ready)) begin
        g = 0;
        for (int i = 0; i < NR; i++) if (upd_ready[i]) g = i;
        eg = -1;
        for (int k = 0; k < NR; k++) begin
          c = (m_ptr + k) % NR;
          if (eg < 0 && upd_valid[c]) eg = c;
        end
        chk("grant_idx", 64'(g), 64'(eg));
        grant_log.push_back(g);
        m_ptr = (g + 1) % NR;
        op = upd_op[g];
        a = upd_addr[g*AW +: AW];
        d = upd_data[g*DW +: DW];
        err = op && !m_occ[a];
        if (!op) begin
          if (m_occ[a]) exp_q.push_back({1'b1, a, {DW{1'b0}}});
          exp_q.push_back({1'b0, a, d});
          m_occ[a] = 1'b1;
          m_data[a] = d;
        end else if (m_occ[a]) begin
          exp_q.push_back({1'b1, a, {DW{1'b0}}});
          m_occ[a] = 1'b0;
        end
        done_q.push_back({IDW'(g), err, m_occ});
      end
      // CAM write strobes
      if (cam_write_enable || cam_write_delete) begin
        if (cam_write_enable) n_wen++; else n_del++;
        if (cam_write_enable) wen_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_cam_write", 64'd1, 64'd0);
        else begin
          pe = exp_q.pop_front();
          chk("cam_write_is_delete", {63'd0, cam_write_delete}, {63'd0, pe[PW-1]});
          chk("cam_write_addr", 64'(cam_write_addr), 64'(pe[DW+AW-1:DW]));
          if (cam_write_enable) chk("cam_write_data", cam_write_data, pe[DW-1:0]);
        end
      end
      // completions
      if (done_valid) begin
        n_done++;
        last_err = done_err;
        if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          de = done_q.pop_front();
          chk("done_id", 64'(done_id), 64'(de[DQW-1 -: IDW]));
          chk("done_err", 64'(done_err), 64'(de[NENT]));
          chk("occupied_at_done", 64'(occupied), 64'(de[NENT-1:0]));
          chk("writes_left_at_done", 64'(exp_q.size()), 64'd0);
        end
      end
      // lookup responses, then accepts
      if (lk_resp_valid) begin
        n_resp++;
        last_hit = lk_hit;
        last_addr = lk_addr;
        last_lat = cyc - acc_cyc;
        if (lk_q.size() == 0) chk("unexpected_lk_resp", 64'd1, 64'd0);
        else begin
          le = lk_q.pop_front();
          chk("lk_resp_cycle", 64'(cyc), 64'(le[LQW-1 -: 32]));
          chk("lk_hit", 64'(lk_hit), 64'(le[AW]));
          if (le[AW]) chk("lk_addr", 64'(lk_addr), 64'(le[AW-1:0]));
        end
      end else if (lk_q.size() > 0 && int'(lk_q[0][LQW-1 -: 32]) <= cyc) begin
        chk("lk_resp_missing", 64'd0, 64'd1);
        void'(lk_q.pop_front());
      end
      if (lk_valid && lk_ready) begin
        acc_cyc = cyc;
        hit = 1'b0;
        ha = '0;
        for (int i = NENT - 1; i >= 0; i--)
          if (m_occ[i] && m_data[i] == lk_data) begin hit = 1'b1; ha = AW'(i); end
        lk_q.push_back({32'(cyc + 2), hit, ha});
      end
    end
  end

  // ---------------- driver tasks (all start and end on a falling edge) ----------------
  task automatic set_req(input int i, input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    upd_op[i] = op;
    upd_addr[i*AW +: AW] = a;
    upd_data[i*DW +: DW] = d;
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 300; c++) begin
      if (n_done >= target) return;
      @(negedge clk); #3;
    end
    chk("timeout_wait_done", 64'(n_done), 64'(target));
  endtask

  // raise the masked requests, drop each one after its grant, await n completions
  task automatic run_upd(input logic [NR-1:0] mask, input int n);
    int target;
    logic [NR-1:0] g;
    target = n_done + n;
    upd_valid = mask;
    for (int c = 0; c < 400; c++) begin
      #3;
      g = upd_valid & upd_ready;
      @(negedge clk);
      upd_valid = upd_valid & ~g;
      if (upd_valid == '0) begin
        #3;
        wait_done(target);
        @(negedge clk);
        return;
      end
    end
    chk("timeout_grant", 64'(upd_valid), 64'd0);
    upd_valid = '0;
  endtask

  task automatic lookup(input logic [DW-1:0] key);
    int r0;
    logic ok;
    r0 = n_resp;
    ok = 1'b0;
    lk_data = key;
    lk_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #3;
      if (lk_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    lk_valid = 1'b0;
    if (!ok) chk("timeout_lk_accept", 64'd0, 64'd1);
    for (int c = 0; c < 20 && n_resp == r0; c++) begin @(negedge clk); #3; end
    if (n_resp == r0) chk("timeout_lk_resp", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_upd_ready"}, 64'(upd_ready), 64'd0);
    chk({tag, "_lk_ready"}, 64'(lk_ready), 64'd0);
    chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
    chk({tag, "_wr_en_del"}, {62'd0, cam_write_enable, cam_write_delete}, 64'd0);
    chk({tag, "_wr_addr"}, 64'(cam_write_addr), 64'd0);
    chk({tag, "_wr_data"}, cam_write_data, 64'd0);
    chk({tag, "_lk_resp"}, {62'd0, lk_resp_valid, lk_hit}, 64'd0);
    chk({tag, "_occupied"}, 64'(occupied), 64'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int hi_cycles, d0, w0, x0, gl;
    logic ok;
    upd_valid = '0; upd_op = '0; upd_addr = '0; upd_data = '0;
    lk_valid = 1'b0; lk_data = '0;

    // reset with a request already pending: nothing may be granted
    init_cyc = 20;
    set_req(0, 1'b0, 5'd10, 64'h55);
    upd_valid = 2'b01;
    repeat (3) @(negedge clk);
    #3 check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // CAM init busy: no ready while busy, first grant the cycle after it falls
    hi_cycles = 0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #3;
      if (cam_write_busy) begin
        chk("init_upd_ready", 64'(upd_ready), 64'd0);
        chk("init_lk_ready", 64'(lk_ready), 64'd0);
        hi_cycles++;
        @(negedge clk);
      end else begin
        chk("busy_fall_cycle_no_grant", 64'(upd_ready), 64'd0);
        @(negedge clk); #3;
        chk("first_grant_after_busy", 64'(upd_ready), 64'b01);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_init", 64'd0, 64'd1);
    chk("init_busy_long", 64'(hi_cycles >= 18), 64'd1);
    @(negedge clk);
    upd_valid = '0;
    wait_done(1);
    @(negedge clk);
    chk("occ_after_first_add", 64'(occupied), 64'h400);

    // fresh start with a short CAM init
    init_cyc = 3;
    rst_n = 1'b0;
    #1 chk("reset2_occupied", 64'(occupied), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // both requesters add at once: grant 0 then 1, one write each
    set_req(0, 1'b0, 5'd3, 64'h1111);
    set_req(1, 1'b0, 5'd7, 64'h7777);
    w0 = n_wen; gl = grant_log.size();
    run_upd(2'b11, 2);
    chk("rr_log_len", 64'(grant_log.size() - gl), 64'd2);
    if (grant_log.size() >= gl + 2) begin
      chk("rr_first", 64'(grant_log[gl]), 64'd0);
      chk("rr_second", 64'(grant_log[gl+1]), 64'd1);
    end
    chk("two_add_writes", 64'(n_wen - w0), 64'd2);
    chk("occ_two_adds", 64'(occupied), 64'h88);

    // replace: add onto occupied entry 3
    set_req(0, 1'b0, 5'd3, 64'hAB);
    w0 = n_wen; x0 = n_del; d0 = n_done;
    run_upd(2'b01, 1);
    chk("replace_deletes", 64'(n_del - x0), 64'd1);
    chk("replace_writes", 64'(n_wen - w0), 64'd1);
    chk("replace_dones", 64'(n_done - d0), 64'd1);
    chk("replace_err", 64'(last_err), 64'd0);
    chk("occ_after_replace", 64'(occupied), 64'h88);

    // delete of an empty entry: error, no CAM access
    set_req(1, 1'b1, 5'd5, 64'h0);
    w0 = n_wen; x0 = n_del;
    run_upd(2'b10, 1);
    chk("del_empty_err", 64'(last_err), 64'd1);
    chk("del_empty_no_delete", 64'(n_del - x0), 64'd0);
    chk("del_empty_no_write", 64'(n_wen - w0), 64'd0);
    chk("occ_after_del_empty", 64'(occupied), 64'h88);

    // lookups
    lookup(64'hAB);
    chk("lk_ab_hit", 64'(last_hit), 64'd1);
    chk("lk_ab_addr", 64'(last_addr), 64'd3);
    chk("lk_ab_latency", 64'(last_lat), 64'd2);
    lookup(64'h7777);
    chk("lk_7777_hit", 64'(last_hit), 64'd1);
    chk("lk_7777_addr", 64'(last_addr), 64'd7);
    lookup(64'h1111);
    chk("lk_replaced_miss", 64'(last_hit), 64'd0);
    lookup(64'h9999);
    chk("lk_absent_miss", 64'(last_hit), 64'd0);

    // delete an occupied entry
    set_req(0, 1'b1, 5'd7, 64'h0);
    x0 = n_del;
    run_upd(2'b01, 1);
    chk("del_one_pulse", 64'(n_del - x0), 64'd1);
    chk("del_err", 64'(last_err), 64'd0);
    chk("occ_after_del", 64'(occupied), 64'h08);
    lookup(64'h7777);
    chk("lk_deleted_miss", 64'(last_hit), 64'd0);

    // round robin resumes after requester 0: requester 1 first
    set_req(0, 1'b1, 5'd3, 64'h0);
    set_req(1, 1'b0, 5'd12, 64'hC);
    gl = grant_log.size();
    run_upd(2'b11, 2);
    if (grant_log.size() >= gl + 2) begin
      chk("rr2_first", 64'(grant_log[gl]), 64'd1);
      chk("rr2_second", 64'(grant_log[gl+1]), 64'd0);
    end else chk("rr2_log_len", 64'(grant_log.size() - gl), 64'd2);
    chk("occ_rr2", 64'(occupied), 64'h1000);

    // reset asserted while waiting for the write to finish
    set_req(0, 1'b0, 5'd20, 64'h2020);
    w0 = n_wen; d0 = n_done;
    upd_valid = 2'b01;
    for (int c = 0; c < 100; c++) begin #3; if (upd_ready[0]) break; @(negedge clk); end
    @(negedge clk);
    upd_valid = '0;
    for (int c = 0; c < 100; c++) begin #3; if (n_wen > w0) break; @(negedge clk); end
    chk("abort_write_seen", 64'(n_wen - w0), 64'd1);
    repeat (2) @(negedge clk);
    #3 chk("abort_in_wr_wait_lo", 64'(dbg_state), 64'd7);
    rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", 64'(n_done - d0), 64'd0);

    // recovery after the abort
    set_req(1, 1'b0, 5'd4, 64'h44);
    run_upd(2'b10, 1);
    chk("occ_recovered", 64'(occupied), 64'h10);
    lookup(64'h44);
    chk("lk_recovered_hit", 64'(last_hit), 64'd1);
    chk("lk_recovered_addr", 64'(last_addr), 64'd4);

    repeat (3) @(negedge clk);
    chk("queues_drained", 64'(exp_q.size() + done_q.size() + lk_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
